// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read, write, issue and flush signals of the scoreboarded register file
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
);
  logic [AW-1:0]    rd0_addr_i, rd1_addr_i;
  logic [XLEN-1:0]  rd0_data_o, rd1_data_o;
  logic             rd0_busy_o, rd1_busy_o;
  logic             wr0_we_i, wr1_we_i;
  logic [AW-1:0]    wr0_addr_i, wr1_addr_i;
  logic [XLEN-1:0]  wr0_data_i, wr1_data_i;
  logic             iss_vld_i;
  logic [AW-1:0]    iss_rd_i;
  logic             flush_i;
  logic [NREGS-1:0] busy_vec_o;
  modport slave (
    input  rd0_addr_i, rd1_addr_i, wr0_we_i, wr0_addr_i, wr0_data_i,
           wr1_we_i, wr1_addr_i, wr1_data_i, iss_vld_i, iss_rd_i, flush_i,
    output rd0_data_o, rd1_data_o, rd0_busy_o, rd1_busy_o, busy_vec_o
  );
  modport master (
    output rd0_addr_i, rd1_addr_i, wr0_we_i, wr0_addr_i, wr0_data_i,
           wr1_we_i, wr1_addr_i, wr1_data_i, iss_vld_i, iss_rd_i, flush_i,
    input  rd0_data_o, rd1_data_o, rd0_busy_o, rd1_busy_o, busy_vec_o
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/2W register file with busy scoreboard; register 0 is hardwired to zero.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle write data and busy clears to the read ports.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy, busy_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else begin
      if (bus.wr0_we_i && bus.wr0_addr_i != '0) regs[bus.wr0_addr_i] <= bus.wr0_data_i;
      if (bus.wr1_we_i && bus.wr1_addr_i != '0) regs[bus.wr1_addr_i] <= bus.wr1_data_i;
    end
  // later assignments win: writeback clear, then issue set, then flush
  always_comb begin
    busy_nxt = busy;
    if (bus.wr0_we_i) busy_nxt[bus.wr0_addr_i] = 1'b0;
    if (bus.wr1_we_i) busy_nxt[bus.wr1_addr_i] = 1'b0;
    if (bus.iss_vld_i) busy_nxt[bus.iss_rd_i] = 1'b1;
    if (bus.flush_i) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= busy_nxt;
  assign bus.busy_vec_o = busy;
`ifdef REGFILE_SB_BYPASS_EN
  logic h0_0, h1_0, h0_1, h1_1;
  assign h0_0 = bus.wr0_we_i && bus.wr0_addr_i == bus.rd0_addr_i && bus.rd0_addr_i != '0;
  assign h1_0 = bus.wr1_we_i && bus.wr1_addr_i == bus.rd0_addr_i && bus.rd0_addr_i != '0;
  assign h0_1 = bus.wr0_we_i && bus.wr0_addr_i == bus.rd1_addr_i && bus.rd1_addr_i != '0;
  assign h1_1 = bus.wr1_we_i && bus.wr1_addr_i == bus.rd1_addr_i && bus.rd1_addr_i != '0;
  assign bus.rd0_data_o = h1_0 ? bus.wr1_data_i : h0_0 ? bus.wr0_data_i : regs[bus.rd0_addr_i];
  assign bus.rd1_data_o = h1_1 ? bus.wr1_data_i : h0_1 ? bus.wr0_data_i : regs[bus.rd1_addr_i];
  assign bus.rd0_busy_o = (h0_0 || h1_0) && !(bus.iss_vld_i && bus.iss_rd_i == bus.rd0_addr_i)
                          ? 1'b0 : busy[bus.rd0_addr_i];
  assign bus.rd1_busy_o = (h0_1 || h1_1) && !(bus.iss_vld_i && bus.iss_rd_i == bus.rd1_addr_i)
                          ? 1'b0 : busy[bus.rd1_addr_i];
`else
  assign bus.rd0_data_o = regs[bus.rd0_addr_i];
  assign bus.rd1_data_o = regs[bus.rd1_addr_i];
  assign bus.rd0_busy_o = busy[bus.rd0_addr_i];
  assign bus.rd1_busy_o = busy[bus.rd1_addr_i];
`endif
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and random checks of regfile_sb against an array-based reference model
module tb_regfile_sb;
  localparam int XLEN = 32, NREGS = 32, AW = 5;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_assert = 0, n_fail = 0;
  logic [XLEN-1:0] m_reg [NREGS];
  logic [NREGS-1:0] m_busy;
  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) bus ();
  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
    m_busy = '0;
  endtask

  task automatic idle();
    bus.wr0_we_i = 0; bus.wr1_we_i = 0; bus.iss_vld_i = 0; bus.flush_i = 0;
    bus.wr0_addr_i = '0; bus.wr1_addr_i = '0; bus.iss_rd_i = '0;
    bus.wr0_data_i = '0; bus.wr1_data_i = '0;
  endtask

  task automatic cyc(input bit w0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                     input bit w1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                     input bit iv, input logic [AW-1:0] ir, input bit fl);
    bus.wr0_we_i = w0; bus.wr0_addr_i = a0; bus.wr0_data_i = d0;
    bus.wr1_we_i = w1; bus.wr1_addr_i = a1; bus.wr1_data_i = d1;
    bus.iss_vld_i = iv; bus.iss_rd_i = ir; bus.flush_i = fl;
    @(posedge clk);
    #1;
    if (w0 && a0 != 0) m_reg[a0] = d0;
    if (w1 && a1 != 0) m_reg[a1] = d1;
    if (w0) m_busy[a0] = 1'b0;
    if (w1) m_busy[a1] = 1'b0;
    if (iv && ir != 0) m_busy[ir] = 1'b1;
    if (fl) m_busy = '0;
    idle();
  endtask

  task automatic chk_rd(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b);
    bus.rd0_addr_i = a; bus.rd1_addr_i = b;
    #1;
    chk({tag, "_rd0"}, bus.rd0_data_o, m_reg[a]);
    chk({tag, "_rd1"}, bus.rd1_data_o, m_reg[b]);
    chk({tag, "_bz0"}, {31'd0, bus.rd0_busy_o}, {31'd0, m_busy[a]});
    chk({tag, "_bz1"}, {31'd0, bus.rd1_busy_o}, {31'd0, m_busy[b]});
    chk({tag, "_vec"}, bus.busy_vec_o, m_busy);
  endtask

  initial begin
    idle();
    bus.rd0_addr_i = '0; bus.rd1_addr_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vec", bus.busy_vec_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) chk_rd("reset", AW'(i), AW'(NREGS - 1 - i));

    cyc(1, 5'd5, 32'h11111111, 1, 5'd5, 32'h22222222, 0, 0, 0);
    chk("dual_wr", m_reg[5], 32'h22222222);
    chk_rd("dual", 5'd5, 5'd0);

    cyc(1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 1, 5'd0, 0);
    chk_rd("reg0", 5'd0, 5'd0);
    chk("reg0_busy", {31'd0, bus.busy_vec_o[0]}, 32'd0);

    cyc(0, 0, 0, 0, 0, 0, 1, 5'd7, 0);
    chk_rd("iss7", 5'd7, 5'd5);
    cyc(1, 5'd7, 32'hA5A5A5A5, 0, 0, 0, 1, 5'd7, 0);
    chk("set_wins", {31'd0, bus.busy_vec_o[7]}, 32'd1);
    chk_rd("iss_wr7", 5'd7, 5'd7);
    cyc(0, 0, 0, 1, 5'd7, 32'h5A5A5A5A, 0, 0, 0);
    chk("wb_clear", {31'd0, bus.busy_vec_o[7]}, 32'd0);
    chk_rd("wr7", 5'd7, 5'd0);

    cyc(0, 0, 0, 0, 0, 0, 1, 5'd3, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd4, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 5'd9, 0);
    chk("pre_flush", bus.busy_vec_o, 32'h0000_0218);
    cyc(1, 5'd20, 32'hCAFEF00D, 0, 0, 0, 1, 5'd3, 1);
    chk("flush", bus.busy_vec_o, '0);
    chk_rd("flush_wr", 5'd20, 5'd3);

    bus.rd0_addr_i = 5'd12; bus.rd1_addr_i = 5'd12;
    bus.wr0_we_i = 1; bus.wr0_addr_i = 5'd12; bus.wr0_data_i = 32'hDEADBEEF;
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    chk("byp_same", bus.rd0_data_o, 32'hDEADBEEF);
`else
    chk("byp_same", bus.rd0_data_o, m_reg[12]);
`endif
    chk("byp_busy", {31'd0, bus.rd0_busy_o}, 32'd0);
    cyc(1, 5'd12, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    chk("byp_next", bus.rd1_data_o, 32'hDEADBEEF);

    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] a0, a1, ir;
      a0 = AW'($urandom); a1 = $urandom_range(0, 3) == 0 ? a0 : AW'($urandom);
      ir = $urandom_range(0, 2) == 0 ? a0 : AW'($urandom);
      cyc(1'($urandom), a0, $urandom, 1'($urandom), a1, $urandom,
          1'($urandom), ir, $urandom_range(0, 15) == 0);
      chk_rd("rand", AW'($urandom), AW'($urandom));
    end

    bus.wr0_we_i = 1; bus.wr0_addr_i = 5'd6; bus.wr0_data_i = 32'h12345678;
    bus.iss_vld_i = 1; bus.iss_rd_i = 5'd6;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_vec", bus.busy_vec_o, '0);
    @(posedge clk);
    #1;
    chk_rd("mid_rst", 5'd6, 5'd5);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    cyc(1, 5'd6, 32'h0BADCAFE, 0, 0, 0, 1, 5'd9, 0);
    chk_rd("post_rst", 5'd6, 5'd9);
    chk("post_rst_busy9", {31'd0, bus.busy_vec_o[9]}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
